// File: rtl/ddr_channel_arbiter.sv
// ============================================================================
// ddr_channel_arbiter: shares one DDR load/store channel between M0 (ifetch)
// and M1 (data side), one transaction in flight.   Rev 1.0
// ============================================================================
`default_nettype none

module ddr_channel_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  m0_load_request_i,
  input  logic [ADDR_WIDTH-1:0] m0_load_address_i,
  input  logic                  m0_load_invalidate_i,
  output logic [DATA_WIDTH-1:0] m0_load_data_o,
  output logic                  m0_load_valid_o,
  input  logic                  m1_load_request_i,
  input  logic [ADDR_WIDTH-1:0] m1_load_address_i,
  input  logic                  m1_load_invalidate_i,
  output logic [DATA_WIDTH-1:0] m1_load_data_o,
  output logic                  m1_load_valid_o,
  input  logic                  m1_store_request_i,
  input  logic [ADDR_WIDTH-1:0] m1_store_address_i,
  input  logic [DATA_WIDTH-1:0] m1_store_data_i,
  output logic                  m1_store_done_o,
  output logic                  ddr_load_request_o,
  output logic [ADDR_WIDTH-1:0] ddr_load_address_o,
  output logic                  ddr_load_invalidate_o,
  input  logic [DATA_WIDTH-1:0] ddr_load_data_i,
  input  logic                  ddr_load_valid_i,
  output logic                  ddr_store_request_o,
  output logic [ADDR_WIDTH-1:0] ddr_store_address_o,
  output logic [DATA_WIDTH-1:0] ddr_store_data_o,
  input  logic                  ddr_store_done_i,
  output logic                  timeout_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_LOAD_WAIT  = 2'd1,
    S_STORE_WAIT = 2'd2
  } state_t;

  state_t                state_q;
  logic                  owner_q;
  logic                  rr_q;
  logic [CW-1:0]         cnt_q;
  logic                  p0l_q, p1l_q, p1s_q;
  logic [ADDR_WIDTH-1:0] p0l_addr_q, p1l_addr_q, p1s_addr_q;
  logic [DATA_WIDTH-1:0] p1s_data_q;
  logic                  ddr_ld_req_q, ddr_ld_inv_q, ddr_st_req_q;
  logic [ADDR_WIDTH-1:0] ddr_ld_addr_q, ddr_st_addr_q;
  logic [DATA_WIDTH-1:0] ddr_st_data_q;
  logic                  timeout_q;

  logic                  in_load, in_store, ddr_resp, tmo, cancel, load_done;
  logic                  free, m0_want, m1_want, contend;
  logic                  grant_m0, grant_m1, grant_l1, grant_s;
  logic                  p0l_d, p1l_d, p1s_d;
  logic [ADDR_WIDTH-1:0] p0l_addr_cur, p1l_addr_cur, p1s_addr_cur;
  logic [DATA_WIDTH-1:0] p1s_data_cur, load_data;

  assign in_load  = (state_q == S_LOAD_WAIT);
  assign in_store = (state_q == S_STORE_WAIT);
  assign ddr_resp = (in_load & ddr_load_valid_i) | (in_store & ddr_store_done_i);
  assign tmo      = (in_load | in_store) & (cnt_q == C_CNT_LAST) & ~ddr_resp;
  // An owner cancel loses to a same-cycle DDR valid and also suppresses the timeout valid.
  assign cancel    = in_load & ~ddr_load_valid_i &
                     (owner_q ? m1_load_invalidate_i : m0_load_invalidate_i);
  assign load_done = in_load & (ddr_load_valid_i | (tmo & ~cancel));
  assign load_data = ddr_load_valid_i ? ddr_load_data_i : '0;

  assign m0_load_valid_o = load_done & ~owner_q;
  assign m1_load_valid_o = load_done & owner_q;
  assign m0_load_data_o  = m0_load_valid_o ? load_data : '0;
  assign m1_load_data_o  = m1_load_valid_o ? load_data : '0;
  assign m1_store_done_o = in_store & (ddr_store_done_i | tmo);

  // Requests arriving this cycle are visible to the grant so the DDR pulse lands next cycle.
  assign p0l_d = (p0l_q | m0_load_request_i) & ~m0_load_invalidate_i;
  assign p1l_d = (p1l_q | m1_load_request_i) & ~m1_load_invalidate_i;
  assign p1s_d = p1s_q | m1_store_request_i;

  assign p0l_addr_cur = p0l_q ? p0l_addr_q : m0_load_address_i;
  assign p1l_addr_cur = p1l_q ? p1l_addr_q : m1_load_address_i;
  assign p1s_addr_cur = p1s_q ? p1s_addr_q : m1_store_address_i;
  assign p1s_data_cur = p1s_q ? p1s_data_q : m1_store_data_i;

  assign free     = (state_q == S_IDLE) | ddr_resp;
  assign m0_want  = free & p0l_d;
  assign m1_want  = free & (p1l_d | p1s_d);
  assign contend  = m0_want & m1_want;
  assign grant_m1 = m1_want & (~m0_want | rr_q);
  assign grant_m0 = m0_want & ~grant_m1;
  assign grant_s  = grant_m1 & p1s_d;
  assign grant_l1 = grant_m1 & ~p1s_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= S_IDLE;
      owner_q       <= 1'b0;
      rr_q          <= 1'b0;
      cnt_q         <= '0;
      p0l_q         <= 1'b0;
      p1l_q         <= 1'b0;
      p1s_q         <= 1'b0;
      p0l_addr_q    <= '0;
      p1l_addr_q    <= '0;
      p1s_addr_q    <= '0;
      p1s_data_q    <= '0;
      ddr_ld_req_q  <= 1'b0;
      ddr_ld_addr_q <= '0;
      ddr_ld_inv_q  <= 1'b0;
      ddr_st_req_q  <= 1'b0;
      ddr_st_addr_q <= '0;
      ddr_st_data_q <= '0;
      timeout_q     <= 1'b0;
    end else begin
      p0l_q <= p0l_d & ~grant_m0;
      p1l_q <= p1l_d & ~grant_l1;
      p1s_q <= p1s_d & ~grant_s;
      if (m0_load_request_i)  p0l_addr_q <= m0_load_address_i;
      if (m1_load_request_i)  p1l_addr_q <= m1_load_address_i;
      if (m1_store_request_i) begin
        p1s_addr_q <= m1_store_address_i;
        p1s_data_q <= m1_store_data_i;
      end

      // The pointer only moves when both masters actually competed.
      if (contend) rr_q <= ~rr_q;

      ddr_ld_req_q <= grant_m0 | grant_l1;
      if (grant_m0)      ddr_ld_addr_q <= p0l_addr_cur;
      else if (grant_l1) ddr_ld_addr_q <= p1l_addr_cur;
      ddr_st_req_q <= grant_s;
      if (grant_s) begin
        ddr_st_addr_q <= p1s_addr_cur;
        ddr_st_data_q <= p1s_data_cur;
      end
      ddr_ld_inv_q <= cancel | (in_load & tmo);
      if (tmo) timeout_q <= 1'b1;

      if (grant_m0 | grant_l1) begin
        state_q <= S_LOAD_WAIT;
        owner_q <= grant_l1;
        cnt_q   <= '0;
      end else if (grant_s) begin
        state_q <= S_STORE_WAIT;
        cnt_q   <= '0;
      end else if (ddr_resp | tmo | cancel) begin
        state_q <= S_IDLE;
      end else if (state_q != S_IDLE) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign ddr_load_request_o    = ddr_ld_req_q;
  assign ddr_load_address_o    = ddr_ld_addr_q;
  assign ddr_load_invalidate_o = ddr_ld_inv_q;
  assign ddr_store_request_o   = ddr_st_req_q;
  assign ddr_store_address_o   = ddr_st_addr_q;
  assign ddr_store_data_o      = ddr_st_data_q;
  assign timeout_o             = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_ddr_channel_arbiter.sv
// ============================================================================
// tb_ddr_channel_arbiter: directed scoreboard bench for ddr_channel_arbiter.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ddr_channel_arbiter;

  localparam logic [2:0] K_DLD = 3'd0, K_DST = 3'd1, K_DINV = 3'd2,
                         K_M0V = 3'd3, K_M1V = 3'd4, K_M1D = 3'd5;

  typedef struct packed {
    logic [2:0]  k;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 0, m0_inv = 0, m1_req = 0, m1_inv = 0, m1_st = 0;
  logic [31:0] m0_addr = 0, m1_addr = 0, m1_st_addr = 0, m1_st_data = 0;
  logic [31:0] m0_data, m1_data, ddr_ld_addr, ddr_st_addr, ddr_st_data;
  logic        m0_val, m1_val, m1_done, ddr_ld_req, ddr_ld_inv, ddr_st_req, tmo;
  logic [31:0] ddr_data = 0;
  logic        ddr_val = 0, ddr_done = 0;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;

  always #5 clk = ~clk;

  ddr_channel_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_load_request_i(m0_req), .m0_load_address_i(m0_addr),
    .m0_load_invalidate_i(m0_inv), .m0_load_data_o(m0_data), .m0_load_valid_o(m0_val),
    .m1_load_request_i(m1_req), .m1_load_address_i(m1_addr),
    .m1_load_invalidate_i(m1_inv), .m1_load_data_o(m1_data), .m1_load_valid_o(m1_val),
    .m1_store_request_i(m1_st), .m1_store_address_i(m1_st_addr),
    .m1_store_data_i(m1_st_data), .m1_store_done_o(m1_done),
    .ddr_load_request_o(ddr_ld_req), .ddr_load_address_o(ddr_ld_addr),
    .ddr_load_invalidate_o(ddr_ld_inv), .ddr_load_data_i(ddr_data),
    .ddr_load_valid_i(ddr_val), .ddr_store_request_o(ddr_st_req),
    .ddr_store_address_o(ddr_st_addr), .ddr_store_data_o(ddr_st_data),
    .ddr_store_done_i(ddr_done), .timeout_o(tmo)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [2:0] k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.k = k; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input logic [2:0] k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    total++;
    assert (exp_q.size() != 0) else begin
      bad++;
      $error("FAIL unexpected_event observed kind=%0d addr=%h data=%h expected none", k, a, d);
      return;
    end
    e = exp_q.pop_front();
    assert (k === e.k && a === e.a && d === e.d) else begin
      bad++;
      $error("FAIL event observed kind=%0d addr=%h data=%h expected kind=%0d addr=%h data=%h",
             k, a, d, e.k, e.a, e.d);
    end
  endtask

  // Scoreboard monitor: every output event pops the next expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ddr_ld_req) check_ev(K_DLD, ddr_ld_addr, 32'h0);
      if (ddr_st_req) check_ev(K_DST, ddr_st_addr, ddr_st_data);
      if (ddr_ld_inv) check_ev(K_DINV, 32'h0, 32'h0);
      if (m0_val)     check_ev(K_M0V, 32'h0, m0_data);
      if (m1_val)     check_ev(K_M1V, 32'h0, m1_data);
      if (m1_done)    check_ev(K_M1D, 32'h0, 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    ticks(2);
    check("rst_ddr_ld_req", {31'h0, ddr_ld_req}, 32'h0);
    check("rst_ddr_st_req", {31'h0, ddr_st_req}, 32'h0);
    check("rst_timeout", {31'h0, tmo}, 32'h0);
    rst_n = 1'b1;
    ticks(2);

    // 1: single M0 load
    m0_req = 1; m0_addr = 32'h8000_0040; push(K_DLD, 32'h8000_0040, 0);
    tick(); m0_req = 0;
    check("t1_req_latency", {31'h0, ddr_ld_req}, 32'h1);
    ticks(4);
    ddr_val = 1; ddr_data = 32'hDEAD_BEEF; push(K_M0V, 0, 32'hDEAD_BEEF);
    #1;
    check("t1_m0_valid", {31'h0, m0_val}, 32'h1);
    check("t1_m0_data", m0_data, 32'hDEAD_BEEF);
    check("t1_m1_quiet", {31'h0, m1_val}, 32'h0);
    tick(); ddr_val = 0;
    ticks(2);

    // 2: contention, M0 first then round-robin keeps M1 ahead on the repeat
    m0_req = 1; m0_addr = 32'h100; m1_req = 1; m1_addr = 32'h200;
    push(K_DLD, 32'h100, 0);
    tick(); m0_req = 0; m1_req = 0;
    ticks(2);
    ddr_val = 1; ddr_data = 32'h11; push(K_M0V, 0, 32'h11); push(K_DLD, 32'h200, 0);
    tick(); ddr_val = 0;
    check("t2_second_issue", {31'h0, ddr_ld_req}, 32'h1);
    check("t2_second_addr", ddr_ld_addr, 32'h200);
    ddr_val = 1; ddr_data = 32'h22; push(K_M1V, 0, 32'h22);
    tick(); ddr_val = 0;
    ticks(2);
    m0_req = 1; m0_addr = 32'h100; m1_req = 1; m1_addr = 32'h200;
    push(K_DLD, 32'h200, 0);
    tick(); m0_req = 0; m1_req = 0;
    check("t2_repeat_first", ddr_ld_addr, 32'h200);
    ddr_val = 1; ddr_data = 32'h33; push(K_M1V, 0, 32'h33); push(K_DLD, 32'h100, 0);
    tick(); ddr_val = 0;
    check("t2_repeat_second", ddr_ld_addr, 32'h100);
    ddr_val = 1; ddr_data = 32'h44; push(K_M0V, 0, 32'h44);
    tick(); ddr_val = 0;
    ticks(2);

    // 3: M1 store beats M1 load
    m1_st = 1; m1_st_addr = 32'h300; m1_st_data = 32'hCAFE;
    m1_req = 1; m1_addr = 32'h304;
    push(K_DST, 32'h300, 32'hCAFE);
    tick(); m1_st = 0; m1_req = 0;
    check("t3_store_first", {31'h0, ddr_st_req}, 32'h1);
    tick();
    ddr_done = 1; push(K_M1D, 0, 0); push(K_DLD, 32'h304, 0);
    #1;
    check("t3_done_fwd", {31'h0, m1_done}, 32'h1);
    tick(); ddr_done = 0;
    tick();
    ddr_val = 1; ddr_data = 32'h55; push(K_M1V, 0, 32'h55);
    tick(); ddr_val = 0;
    ticks(2);

    // 4: owner invalidate mid-flight, stray valid ignored
    m0_req = 1; m0_addr = 32'h400; push(K_DLD, 32'h400, 0);
    tick(); m0_req = 0;
    ticks(3);
    m0_inv = 1; push(K_DINV, 0, 0);
    tick(); m0_inv = 0;
    check("t4_ddr_inv", {31'h0, ddr_ld_inv}, 32'h1);
    tick();
    ddr_val = 1; ddr_data = 32'h99;
    #1;
    check("t4_stray_ignored", {31'h0, m0_val}, 32'h0);
    tick(); ddr_val = 0;
    m1_req = 1; m1_addr = 32'h500; push(K_DLD, 32'h500, 0);
    tick(); m1_req = 0;
    tick();
    ddr_val = 1; ddr_data = 32'h66; push(K_M1V, 0, 32'h66);
    tick(); ddr_val = 0;
    ticks(2);

    // 5: timeout after 16 wait cycles
    m1_req = 1; m1_addr = 32'h600; ddr_data = 32'hFFFF_FFFF;
    push(K_DLD, 32'h600, 0);
    tick(); m1_req = 0;
    ticks(14);
    check("t5_no_early_timeout", {31'h0, tmo}, 32'h0);
    push(K_M1V, 0, 32'h0);
    tick();
    check("t5_abandon_valid", {31'h0, m1_val}, 32'h1);
    check("t5_abandon_data", m1_data, 32'h0);
    push(K_DINV, 0, 0);
    tick();
    check("t5_timeout_set", {31'h0, tmo}, 32'h1);
    check("t5_inv_pulse", {31'h0, ddr_ld_inv}, 32'h1);
    m0_req = 1; m0_addr = 32'h700; push(K_DLD, 32'h700, 0);
    tick(); m0_req = 0;
    ddr_val = 1; ddr_data = 32'h77; push(K_M0V, 0, 32'h77);
    tick(); ddr_val = 0;
    check("t5_timeout_sticky", {31'h0, tmo}, 32'h1);
    ticks(2);

    // 6: reset during LOAD_WAIT with a store pending
    m0_req = 1; m0_addr = 32'h800; push(K_DLD, 32'h800, 0);
    tick(); m0_req = 0;
    m1_st = 1; m1_st_addr = 32'h900; m1_st_data = 32'h1234;
    tick(); m1_st = 0;
    ddr_val = 1; ddr_data = 32'h88; rst_n = 1'b0;
    #1;
    check("t6_rst_m0_valid", {31'h0, m0_val}, 32'h0);
    check("t6_rst_ddr_ld_req", {31'h0, ddr_ld_req}, 32'h0);
    check("t6_rst_ddr_ld_addr", ddr_ld_addr, 32'h0);
    check("t6_rst_timeout", {31'h0, tmo}, 32'h0);
    ticks(2); ddr_val = 0; rst_n = 1'b1;
    ticks(10);
    check("t6_no_issue_st", {31'h0, ddr_st_req}, 32'h0);
    check("sb_empty", exp_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
